// File: rtl/bin_down_counter_pkg.sv
// Shared definitions for the binary down counter: width default and FSM encoding.
package bin_down_counter_pkg;

  // Counter width used when the instantiating code does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Control FSM states. IDLE is the reset state; RUN means a count is in progress.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : bin_down_counter_pkg

// File: rtl/down_count_core.sv
// Datapath for the binary down counter: count register, reload register,
// decrementer and the zero/one detectors the control FSM relies on.
module down_count_core
  import bin_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,          // parallel load of din into count and reload register
  input  logic [WIDTH-1:0] din,
  input  logic             dec,           // decrement count by one this edge
  input  logic             wrap,          // terminal edge in reload mode: count takes reload value
  output logic [WIDTH-1:0] count,
  output logic             count_is_one,
  output logic             din_is_zero
);

  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_d;

  // Next-value selection: load beats wrap beats decrement beats hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    count_d  = count;
    reload_d = reload_q;
    if (load) begin
      count_d  = din;
      reload_d = din;
    end else if (wrap) begin
      count_d = reload_q;
    end else if (dec) begin
      count_d = count - WIDTH'(1);
    end
  end

  // Count and reload registers; reset clears both immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      count    <= '0;
      reload_q <= '0;
    end else begin
      count    <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count_is_one = (count == WIDTH'(1));
  assign din_is_zero  = (din == '0);

endmodule : down_count_core

// File: rtl/bin_down_counter.sv
// Binary down counter with parallel load, count enable and optional auto-reload.
// The top holds the IDLE/RUN control FSM and the terminal-count pulse register;
// the arithmetic lives in down_count_core.
module bin_down_counter
  import bin_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  state_t state_q;
  state_t state_d;
  logic   tc_d;
  logic   dec;
  logic   wrap;
  logic   terminal;
  logic   count_is_one;
  logic   din_is_zero;

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .din          (din),
    .dec          (dec),
    .wrap         (wrap),
    .count        (count),
    .count_is_one (count_is_one),
    .din_is_zero  (din_is_zero)
  );

  // Next-state and datapath controls. Load overrides everything; counting
  // only happens in RUN, so an IDLE counter at zero can never wrap.
  always_comb begin
    state_d  = state_q;
    dec      = 1'b0;
    wrap     = 1'b0;
    terminal = 1'b0;
    tc_d     = 1'b0;
    if (load) begin
      state_d = din_is_zero ? IDLE : RUN;
    end else if (state_q == RUN && en) begin
      dec      = 1'b1;
      terminal = count_is_one;
      if (terminal) begin
        tc_d = 1'b1;
        if (reload) begin
          wrap = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // State and terminal-count pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      tc      <= tc_d;
    end
  end

  // busy is a direct decode of the state flop, so it is registered with no extra stage.
  assign busy = (state_q == RUN);

endmodule : bin_down_counter

// File: tb/tb_bin_down_counter.sv
// Directed self-checking bench for bin_down_counter at WIDTH=4.
module tb_bin_down_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] din;
  logic         en;
  logic         reload;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;

  int tests_run;
  int tests_failed;
  int tc_seen;

  bin_down_counter #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .din    (din),
    .en     (en),
    .reload (reload),
    .count  (count),
    .busy   (busy),
    .tc     (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int exp_count, input bit exp_busy, input bit exp_tc);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".busy"},  32'(busy),  32'(exp_busy));
    check({tag, ".tc"},    32'(tc),    32'(exp_tc));
  endtask

  initial begin
    int exp_a[4];
    int exp_b[9];
    int exp_c[4];
    bit en_c[4];

    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b1;
    load   = 1'b0;
    din    = '0;
    en     = 1'b0;
    reload = 1'b0;

    // Reset value before any clock edge.
    #3;
    check_out("rst_async", 0, 1'b0, 1'b0);

    // Load and en are ignored while reset is high.
    load = 1'b1; din = 4'd7; en = 1'b1;
    tick();
    check_out("rst_ignore", 0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;
    reset = 1'b0;

    // One-shot count from 4.
    load = 1'b1; din = 4'd4; en = 1'b1; reload = 1'b0;
    tick();
    check_out("a_load", 4, 1'b1, 1'b0);
    load = 1'b0;
    exp_a = '{3, 2, 1, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("a_step%0d", i), exp_a[i], i < 3, i == 3);
    end
    tick();
    check_out("a_idle_nowrap", 0, 1'b0, 1'b0);

    // Auto-reload from 3 over 9 enabled edges.
    load = 1'b1; din = 4'd3; reload = 1'b1; en = 1'b1;
    tick();
    check_out("b_load", 3, 1'b1, 1'b0);
    load = 1'b0;
    exp_b = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (tc) tc_seen++;
      check_out($sformatf("b_step%0d", i), exp_b[i], 1'b1, (i % 3) == 2);
    end
    check("b_tc_pulses", 32'(tc_seen), 32'd3);

    // Enable gating from 6.
    load = 1'b1; din = 4'd6; reload = 1'b0; en = 1'b1;
    tick();
    check_out("c_load", 6, 1'b1, 1'b0);
    load = 1'b0;
    exp_c = '{5, 5, 5, 4};
    en_c  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      en = en_c[i];
      tick();
      check_out($sformatf("c_step%0d", i), exp_c[i], 1'b1, 1'b0);
    end

    // Load of zero goes to IDLE; enable is then ignored.
    load = 1'b1; din = 4'd0; en = 1'b1;
    tick();
    check_out("d_load0", 0, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("d_hold%0d", i), 0, 1'b0, 1'b0);
    end

    // Load beats a terminal edge.
    load = 1'b1; din = 4'd1; en = 1'b1;
    tick();
    check_out("e_load1", 1, 1'b1, 1'b0);
    din = 4'd9;
    tick();
    check_out("e_load_over_tc", 9, 1'b1, 1'b0);

    // Full-range count from 15.
    din = 4'd15; reload = 1'b0;
    tick();
    check_out("f_load15", 15, 1'b1, 1'b0);
    load = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tc) tc_seen++;
    end
    check_out("f_end", 0, 1'b0, 1'b1);
    check("f_tc_pulses", 32'(tc_seen), 32'd1);

    // Asynchronous reset mid-count aborts it with no tc.
    load = 1'b1; din = 4'd7; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    check_out("g_at5", 5, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("g_rst_now", 0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tc) tc_seen++;
    end
    check_out("g_after", 0, 1'b0, 1'b0);
    check("g_no_tc", 32'(tc_seen), 32'd0);

    // First edge after reset behaves normally.
    load = 1'b1; din = 4'd2; reload = 1'b1;
    tick();
    check_out("h_load", 2, 1'b1, 1'b0);
    load = 1'b0;
    tick();
    tick();
    check_out("h_wrap", 2, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_bin_down_counter

// File: doc/bin_down_counter.md
BIN_DOWN_COUNTER -- requirements
Module: bin_down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-005 The block SHALL have port din, input, WIDTH bits: load value and reload value.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port reload, input, 1 bit: auto-reload mode select, sampled every edge.
REQ-008 The block SHALL have port count, output, WIDTH bits: the current count value, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN, registered.
REQ-010 The block SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse, registered.

Function
REQ-011 The control FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-012 When load=1 at an edge, the block SHALL set count to din and store din in an internal reload register, regardless of state or en.
REQ-013 On load, the FSM SHALL enter RUN if din!=0 and enter IDLE if din==0.
REQ-014 On a load edge, tc SHALL be 0, even if count==1 and en=1 on that edge.
REQ-015 Load SHALL take priority over en.
REQ-016 In RUN, with load=0 and en=1, count SHALL decrement by 1 per edge, modulo 2^WIDTH arithmetic, with no other operations.
REQ-017 With en=0, count and state SHALL hold, and tc SHALL be 0.
REQ-018 In RUN, with en=1 and count==1 (terminal edge), tc SHALL be 1 for exactly the following cycle.
REQ-019 At a terminal edge with reload=0, count SHALL become 0 and the FSM SHALL enter IDLE, so busy falls on the same edge that tc rises.
REQ-020 At a terminal edge with reload=1, count SHALL become the reload register value and the FSM SHALL stay in RUN.
REQ-021 In IDLE, en SHALL be ignored; count SHALL hold and SHALL never wrap from 0 to 2^WIDTH-1.
REQ-022 tc SHALL be 0 on every edge other than a terminal edge.
REQ-023 In reload mode with a reload value of N>0, tc SHALL pulse once every N enabled cycles, and count SHALL cycle N..1.
REQ-024 All outputs SHALL change only on a clk rising edge or on reset assertion; latency from any input to an output is one edge.

Reset
REQ-025 Asserting reset SHALL force, immediately and without a clock edge: count=0, busy=0, tc=0, reload register=0, FSM=IDLE.
REQ-026 Reset asserted mid-count SHALL abort the count, and no tc SHALL be produced for the aborted count.
REQ-027 While reset is high, load and en SHALL be ignored.
REQ-028 After reset deasserts, the first edge SHALL behave per REQ-012..REQ-022.

Structure
REQ-029 The FSM state encoding (IDLE, RUN) and the WIDTH default SHALL live in the shared package bin_down_counter_pkg.
REQ-030 The datapath (count register, reload register, decrementer, zero/one detect) SHALL be the sub-module down_count_core.
REQ-031 The FSM and the tc register SHALL reside in the top module bin_down_counter.

Verification (WIDTH=4)
REQ-032 Bench: load din=4, reload=0, en=1 held -> count 4,3,2,1,0; tc high only in the cycle count=0; busy 1 then 0 on that edge.
REQ-033 Bench: load din=3, reload=1, en=1 for 9 edges -> count 3,2,1,3,2,1,3,2,1,3; tc pulses 3 times, 3 cycles apart; busy stays 1.
REQ-034 Bench: load din=6, en pattern 1,0,0,1 -> count 6,5,5,5,4; tc stays 0.
REQ-035 Bench: load din=0 -> count 0, busy 0, no tc; then en=1 for 3 edges -> count stays 0.
REQ-036 Bench: count=1 in RUN, load din=9 with en=1 -> count 9, tc 0, busy 1; separately, load din=15 then 15 enabled edges -> count reaches 0 with one tc.
REQ-037 Bench: reset asserted between edges with count=5 -> count=0, busy=0, tc=0 before the next clk edge; no tc follows.
